// File: rtl/dafx_sample_tick_gen_if.sv
// Control/status bundle for the DAFX sample-tick generator: host-side control
// inputs plus per-channel tick, interrupt and overrun status.
interface dafx_sample_tick_gen_if #(
  parameter int NR_OF_CHANNELS_P = 3,
  parameter int COUNTER_WIDTH_P  = 32,
  parameter int OVERRUN_WIDTH_P  = 16
);
  logic [NR_OF_CHANNELS_P-1:0]                 cr_enable;
  logic [NR_OF_CHANNELS_P*COUNTER_WIDTH_P-1:0] cr_divisor;
  logic                                        cr_sync;
  logic [NR_OF_CHANNELS_P-1:0]                 cr_clear_overrun;
  logic [NR_OF_CHANNELS_P-1:0]                 irq_ack;
  logic [NR_OF_CHANNELS_P-1:0]                 sample_tick;
  logic [NR_OF_CHANNELS_P-1:0]                 irq;
  logic [NR_OF_CHANNELS_P*OVERRUN_WIDTH_P-1:0] sr_overrun_count;

  modport master (
    output cr_enable, cr_divisor, cr_sync, cr_clear_overrun, irq_ack,
    input  sample_tick, irq, sr_overrun_count
  );

  modport slave (
    input  cr_enable, cr_divisor, cr_sync, cr_clear_overrun, irq_ack,
    output sample_tick, irq, sr_overrun_count
  );
endinterface

// File: rtl/dafx_sample_tick_gen.sv
// Multi-channel sample-rate tick generator with sticky per-channel interrupts
// and saturating overrun counters for ticks the host did not service in time.
module dafx_sample_tick_gen #(
  parameter int SYS_CLK_FREQUENCY_P  = 125000000,
  parameter int DEFAULT_F_SAMPLING_P = 10000,
  parameter int NR_OF_CHANNELS_P     = 3,
  parameter int COUNTER_WIDTH_P      = 32,
  parameter int OVERRUN_WIDTH_P      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dafx_sample_tick_gen_if.slave bus
);

  localparam int DEFAULT_DIVISOR_C = SYS_CLK_FREQUENCY_P / DEFAULT_F_SAMPLING_P;

  localparam logic [COUNTER_WIDTH_P-1:0] DEF_DIV_C  = COUNTER_WIDTH_P'(DEFAULT_DIVISOR_C);
  localparam logic [COUNTER_WIDTH_P-1:0] MIN_DIV_C  = COUNTER_WIDTH_P'(2);
  localparam logic [COUNTER_WIDTH_P-1:0] CNT_ONE_C  = COUNTER_WIDTH_P'(1);
  localparam logic [COUNTER_WIDTH_P-1:0] CNT_ZERO_C = {COUNTER_WIDTH_P{1'b0}};
  localparam logic [OVERRUN_WIDTH_P-1:0] OVR_ONE_C  = OVERRUN_WIDTH_P'(1);
  localparam logic [OVERRUN_WIDTH_P-1:0] OVR_ZERO_C = {OVERRUN_WIDTH_P{1'b0}};
  localparam logic [OVERRUN_WIDTH_P-1:0] OVR_MAX_C  = {OVERRUN_WIDTH_P{1'b1}};

  logic [NR_OF_CHANNELS_P-1:0][COUNTER_WIDTH_P-1:0] r_cnt;
  logic [NR_OF_CHANNELS_P-1:0][COUNTER_WIDTH_P-1:0] w_cnt_nxt;
  logic [NR_OF_CHANNELS_P-1:0][COUNTER_WIDTH_P-1:0] w_div;
  logic [NR_OF_CHANNELS_P-1:0][COUNTER_WIDTH_P-1:0] w_eff;
  logic [NR_OF_CHANNELS_P-1:0][COUNTER_WIDTH_P-1:0] w_last;
  logic [NR_OF_CHANNELS_P-1:0][OVERRUN_WIDTH_P-1:0] r_ovr;
  logic [NR_OF_CHANNELS_P-1:0][OVERRUN_WIDTH_P-1:0] w_ovr_nxt;
  logic [NR_OF_CHANNELS_P-1:0]                      r_tick;
  logic [NR_OF_CHANNELS_P-1:0]                      w_tick_nxt;
  logic [NR_OF_CHANNELS_P-1:0]                      r_irq;
  logic [NR_OF_CHANNELS_P-1:0]                      w_irq_nxt;

  assign w_div = bus.cr_divisor;

  // Per-channel divide, interrupt and overrun next-state
  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_tick_nxt = {NR_OF_CHANNELS_P{1'b0}};
    w_irq_nxt  = r_irq;
    w_ovr_nxt  = r_ovr;
    w_eff      = {NR_OF_CHANNELS_P{CNT_ZERO_C}};
    w_last     = {NR_OF_CHANNELS_P{CNT_ZERO_C}};
    for (int c = 0; c < NR_OF_CHANNELS_P; c++) begin
      if (w_div[c] == CNT_ZERO_C) begin
        w_eff[c] = DEF_DIV_C;
      end else if (w_div[c] == CNT_ONE_C) begin
        w_eff[c] = MIN_DIV_C;
      end else begin
        w_eff[c] = w_div[c];
      end
      w_last[c] = w_eff[c] - CNT_ONE_C;

      // >= (not ==) lets a shrunken divisor wrap immediately instead of running to overflow
      if (!bus.cr_enable[c]) begin
        w_cnt_nxt[c]  = CNT_ZERO_C;
        w_tick_nxt[c] = 1'b0;
      end else if (bus.cr_sync) begin
        w_cnt_nxt[c]  = CNT_ZERO_C;
        w_tick_nxt[c] = 1'b0;
      end else if (r_cnt[c] >= w_last[c]) begin
        w_cnt_nxt[c]  = CNT_ZERO_C;
        w_tick_nxt[c] = 1'b1;
      end else begin
        w_cnt_nxt[c]  = r_cnt[c] + CNT_ONE_C;
        w_tick_nxt[c] = 1'b0;
      end

      if (w_tick_nxt[c]) begin
        w_irq_nxt[c] = 1'b1;
      end else if (bus.irq_ack[c]) begin
        w_irq_nxt[c] = 1'b0;
      end else begin
        w_irq_nxt[c] = r_irq[c];
      end

      // An ack arriving with the tick counts as serviced, so only unacked pending irqs overrun
      if (bus.cr_clear_overrun[c]) begin
        w_ovr_nxt[c] = OVR_ZERO_C;
      end else if (w_tick_nxt[c] && r_irq[c] && !bus.irq_ack[c] && (r_ovr[c] != OVR_MAX_C)) begin
        w_ovr_nxt[c] = r_ovr[c] + OVR_ONE_C;
      end else begin
        w_ovr_nxt[c] = r_ovr[c];
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= {NR_OF_CHANNELS_P{CNT_ZERO_C}};
      r_tick <= {NR_OF_CHANNELS_P{1'b0}};
      r_irq  <= {NR_OF_CHANNELS_P{1'b0}};
      r_ovr  <= {NR_OF_CHANNELS_P{OVR_ZERO_C}};
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_tick <= w_tick_nxt;
      r_irq  <= w_irq_nxt;
      r_ovr  <= w_ovr_nxt;
    end
  end

  assign bus.sample_tick      = r_tick;
  assign bus.irq              = r_irq;
  assign bus.sr_overrun_count = r_ovr;

endmodule

// File: tb/tb_dafx_sample_tick_gen.sv
// Scoreboard bench for dafx_sample_tick_gen: a period-tracking reference model
// queues expected outputs per cycle, plus directed latency/boundary checks.
module tb_dafx_sample_tick_gen;
  localparam int NCH  = 3;
  localparam int CW   = 32;
  localparam int OW   = 4;
  localparam int OMAX = 15;
  localparam int DDEF = 12500;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dafx_sample_tick_gen_if #(.NR_OF_CHANNELS_P(NCH), .COUNTER_WIDTH_P(CW), .OVERRUN_WIDTH_P(OW)) bus ();

  dafx_sample_tick_gen #(
    .SYS_CLK_FREQUENCY_P(125000000), .DEFAULT_F_SAMPLING_P(10000),
    .NR_OF_CHANNELS_P(NCH), .COUNTER_WIDTH_P(CW), .OVERRUN_WIDTH_P(OW)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [NCH-1:0]    tick;
    logic [NCH-1:0]    irq;
    logic [NCH*OW-1:0] ovr;
  } exp_t;

  exp_t sb_q[$];
  int n_vec = 0;
  int n_err = 0;
  int m_el[NCH];
  int m_ovr[NCH];
  logic [NCH-1:0] m_irq;
  int first[NCH];

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int eff_div(input logic [CW-1:0] d);
    if (d == 32'd0) return DDEF;
    else if (d == 32'd1) return 2;
    else return int'(d);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_el[c]  = 0;
      m_ovr[c] = 0;
    end
    m_irq = '0;
  endtask

  // Reference: m_el counts edges since the period started; a tick ends the period.
  task automatic model_step();
    exp_t e;
    bit   tk;
    int   d;
    e = '0;
    for (int c = 0; c < NCH; c++) begin
      tk = 1'b0;
      d  = eff_div(bus.cr_divisor[c*CW +: CW]);
      if (!bus.cr_enable[c] || bus.cr_sync) begin
        m_el[c] = 0;
      end else begin
        m_el[c] += 1;
        if (m_el[c] >= d) begin
          tk = 1'b1;
          m_el[c] = 0;
        end
      end
      if (bus.cr_clear_overrun[c]) m_ovr[c] = 0;
      else if (tk && m_irq[c] && !bus.irq_ack[c] && m_ovr[c] < OMAX) m_ovr[c] += 1;
      if (tk) m_irq[c] = 1'b1;
      else if (bus.irq_ack[c]) m_irq[c] = 1'b0;
      e.tick[c] = tk;
      e.ovr[c*OW +: OW] = OW'(m_ovr[c]);
    end
    e.irq = m_irq;
    sb_q.push_back(e);
  endtask

  task automatic cycle();
    exp_t e;
    model_step();
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk_eq("tick", 64'(bus.sample_tick), 64'(e.tick));
    chk_eq("irq",  64'(bus.irq), 64'(e.irq));
    chk_eq("ovr",  64'(bus.sr_overrun_count), 64'(e.ovr));
  endtask

  task automatic wait_tick(input int ch, input int budget, input int exp, input string tag);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < budget) begin
      cycle();
      n++;
      seen = bus.sample_tick[ch];
    end
    if (!seen) n = budget + 1;
    chk_eq(tag, 64'(n), 64'(exp));
  endtask

  task automatic set_div(input int ch, input int val);
    bus.cr_divisor[ch*CW +: CW] = CW'(val);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.cr_enable = '0;
    bus.cr_divisor = '0;
    bus.cr_sync = 1'b0;
    bus.cr_clear_overrun = '0;
    bus.irq_ack = '0;
    model_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
      chk_eq("rst_tick", 64'(bus.sample_tick), 64'd0);
      chk_eq("rst_irq",  64'(bus.irq), 64'd0);
      chk_eq("rst_ovr",  64'(bus.sr_overrun_count), 64'd0);
    end
    rst_n = 1'b1;

    // default rate through divisor 0
    bus.cr_enable[0] = 1'b1;
    wait_tick(0, 13000, 12500, "dflt_first");
    wait_tick(0, 13000, 12500, "dflt_period");
    bus.cr_enable[0] = 1'b0;
    bus.irq_ack[0] = 1'b1;
    cycle();
    bus.irq_ack[0] = 1'b0;

    // clamp: divisor 1 behaves as 2, irq held -> every tick after the first overruns
    set_div(1, 1);
    bus.cr_enable[1] = 1'b1;
    repeat (20) cycle();
    chk_eq("clamp_ovr", 64'(bus.sr_overrun_count[OW +: OW]), 64'd9);
    cycle();
    bus.irq_ack[1] = 1'b1;
    cycle();
    bus.irq_ack[1] = 1'b0;
    chk_eq("race_tick", 64'(bus.sample_tick[1]), 64'd1);
    chk_eq("race_irq",  64'(bus.irq[1]), 64'd1);
    chk_eq("race_ovr",  64'(bus.sr_overrun_count[OW +: OW]), 64'd9);
    bus.irq_ack[1] = 1'b1;
    cycle();
    bus.irq_ack[1] = 1'b0;
    chk_eq("ack_clr", 64'(bus.irq[1]), 64'd0);
    cycle();
    set_div(1, 2);
    repeat (20) cycle();
    chk_eq("ovr_sat", 64'(bus.sr_overrun_count[OW +: OW]), 64'd15);
    cycle();
    bus.cr_clear_overrun[1] = 1'b1;
    cycle();
    bus.cr_clear_overrun[1] = 1'b0;
    chk_eq("clr_tick", 64'(bus.sample_tick[1]), 64'd1);
    chk_eq("clr_ovr",  64'(bus.sr_overrun_count[OW +: OW]), 64'd0);
    bus.cr_enable[1] = 1'b0;
    bus.irq_ack[1] = 1'b1;
    cycle();
    bus.irq_ack[1] = 1'b0;

    // divisor shrink and growth mid-period
    set_div(0, 100);
    bus.cr_enable[0] = 1'b1;
    repeat (60) cycle();
    set_div(0, 50);
    cycle();
    chk_eq("shrink_wrap", 64'(bus.sample_tick[0]), 64'd1);
    wait_tick(0, 60, 50, "shrink_period");
    bus.cr_enable[0] = 1'b0;
    cycle();
    set_div(0, 100);
    bus.cr_enable[0] = 1'b1;
    repeat (60) cycle();
    set_div(0, 200);
    wait_tick(0, 300, 140, "grow_ext");
    bus.cr_enable = '0;
    cycle();

    // staggered channels realigned by cr_sync
    set_div(0, 10);
    set_div(1, 15);
    set_div(2, 30);
    bus.cr_enable[0] = 1'b1;
    repeat (3) cycle();
    bus.cr_enable[1] = 1'b1;
    repeat (7) cycle();
    bus.cr_enable[2] = 1'b1;
    repeat (4) cycle();
    bus.cr_sync = 1'b1;
    cycle();
    bus.cr_sync = 1'b0;
    for (int c = 0; c < NCH; c++) first[c] = 0;
    for (int n = 1; n <= 40; n++) begin
      cycle();
      for (int c = 0; c < NCH; c++)
        if (first[c] == 0 && bus.sample_tick[c]) first[c] = n;
    end
    chk_eq("sync_c0", 64'(first[0]), 64'd10);
    chk_eq("sync_c1", 64'(first[1]), 64'd15);
    chk_eq("sync_c2", 64'(first[2]), 64'd30);

    // asynchronous reset mid-period with irqs pending
    repeat (5) cycle();
    #3;
    rst_n = 1'b0;
    #1;
    chk_eq("arst_tick", 64'(bus.sample_tick), 64'd0);
    chk_eq("arst_irq",  64'(bus.irq), 64'd0);
    chk_eq("arst_ovr",  64'(bus.sr_overrun_count), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    chk_eq("arst_hold_irq", 64'(bus.irq), 64'd0);
    rst_n = 1'b1;
    wait_tick(0, 20, 10, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
